// File: rtl/t07_spi_esp32_rx.sv
// -----------------------------------------------------------------------------
// t07_spi_esp32_rx
// Quad-lane (parametrisable) ESP32 SPI receiver.
// LANES-bit beats are deserialised MSB-first into WORD_W-bit words while
// cs_n_in is low. The first word of each chip-select frame is a header whose
// low ADDR_W bits give the start register address. Each following word
// produces a one-cycle write strobe at an auto-incrementing address that
// wraps from 2**ADDR_W-1 back to ADDR_MIN.
//
// Optional feature macro: T07_SPI_RX_PARITY_EN
//   When defined, every word (header included) is followed by one parity beat.
//   Lane i of that beat is the XOR of bit i over the word's data beats.
//
// Ports:
//   clk        system clock, also forwarded on sclk_out
//   rst        asynchronous reset, active-high
//   esp_in     LANES data lanes from the ESP32
//   cs_n_in    chip select, active-low
//   cs_n_out   combinational copy of cs_n_in
//   sclk_out   copy of clk
//   wr_en      one-cycle write strobe to the register file
//   wr_addr    write address, valid with wr_en
//   wr_data    write data, valid with wr_en
//   busy       high while a frame is being received (HEADER or DATA)
//   frame_done one-cycle pulse on a clean end of frame
//   frame_err  one-cycle pulse when the frame ends mid-word
//   par_err    one-cycle pulse on a parity mismatch (0 without the feature)
// -----------------------------------------------------------------------------
module t07_spi_esp32_rx #(
   parameter int LANES    = 4,
   parameter int WORD_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ADDR_MIN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [LANES-1:0]  esp_in,
   input  logic              cs_n_in,
   output logic              cs_n_out,
   output logic              sclk_out,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_err,
   output logic              par_err
);

   localparam int BEATS = WORD_W / LANES;
`ifdef T07_SPI_RX_PARITY_EN
   localparam int PAR_BEATS = 1;
`else
   localparam int PAR_BEATS = 0;
`endif
   localparam int CNT_W = $clog2(BEATS + 1);
   // Beat index that completes a word (data beats plus optional parity beat).
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS + PAR_BEATS - 1);

   typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [WORD_W-1:0] shreg, shreg_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   // armed: cs_n_in has been seen high since reset or since a header parity
   // failure, so a falling chip select may start a new frame.
   logic              armed, armed_nxt;
   logic              wr_en_nxt, frame_done_nxt, frame_err_nxt;
   logic [ADDR_W-1:0] wr_addr_nxt;
   logic [WORD_W-1:0] wr_data_nxt;

   logic [WORD_W-1:0] shreg_shift;
   logic [WORD_W-1:0] word;
   logic              capture;
   logic              word_end;
   logic              shift_en;
   logic              par_ok;

   assign cs_n_out = cs_n_in;
   assign sclk_out = clk;
   assign busy     = (state != IDLE);

   assign shreg_shift = (shreg << LANES) | WORD_W'(esp_in);
   assign capture     = !cs_n_in && ((state != IDLE) || armed);
   assign word_end    = capture && (cnt == LAST);

`ifdef T07_SPI_RX_PARITY_EN
   function automatic logic [LANES-1:0] lane_par(input logic [WORD_W-1:0] w);
      logic [LANES-1:0] p;
      p = '0;
      for (int k = 0; k < BEATS; k++) p ^= w[k*LANES +: LANES];
      return p;
   endfunction

   // The parity beat is not shifted in, so shreg already holds the full word.
   assign shift_en = (cnt != CNT_W'(BEATS));
   assign word     = shreg;
   assign par_ok   = (esp_in == lane_par(shreg));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) par_err <= 1'b0;
      else     par_err <= word_end && !par_ok;
   end
`else
   // The word completes on the edge of its last beat, so use the shifted value.
   assign shift_en = 1'b1;
   assign word     = shreg_shift;
   assign par_ok   = 1'b1;
   assign par_err  = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         shreg      <= '0;
         addr       <= '0;
         armed      <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         shreg      <= shreg_nxt;
         addr       <= addr_nxt;
         armed      <= armed_nxt;
         wr_en      <= wr_en_nxt;
         wr_addr    <= wr_addr_nxt;
         wr_data    <= wr_data_nxt;
         frame_done <= frame_done_nxt;
         frame_err  <= frame_err_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      shreg_nxt      = shreg;
      addr_nxt       = addr;
      armed_nxt      = armed | cs_n_in;
      wr_en_nxt      = 1'b0;
      wr_addr_nxt    = wr_addr;
      wr_data_nxt    = wr_data;
      frame_done_nxt = 1'b0;
      frame_err_nxt  = 1'b0;

      if ((state != IDLE) && cs_n_in) begin
         // Chip select released: clean only on a word boundary after the header.
         state_nxt = IDLE;
         cnt_nxt   = '0;
         if (cnt != '0)         frame_err_nxt  = 1'b1;
         else if (state == DATA) frame_done_nxt = 1'b1;
      end else if (capture) begin
         if (shift_en) shreg_nxt = shreg_shift;
         if (cnt == LAST) begin
            cnt_nxt = '0;
            if (state == DATA) begin
               if (par_ok) begin
                  wr_en_nxt   = 1'b1;
                  wr_addr_nxt = addr;
                  wr_data_nxt = word;
               end
               // Address advances even when a bad word is dropped.
               addr_nxt = (addr == '1) ? ADDR_W'(ADDR_MIN) : addr + ADDR_W'(1);
            end else if (par_ok) begin
               addr_nxt  = word[ADDR_W-1:0];
               state_nxt = DATA;
            end else begin
               // Bad header: ignore the rest of the frame until cs_n_in rises.
               state_nxt = IDLE;
               armed_nxt = 1'b0;
            end
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
            if (state == IDLE) state_nxt = HEADER;
         end
      end
   end

endmodule

// File: tb/tb_t07_spi_esp32_rx.sv
// -----------------------------------------------------------------------------
// tb_t07_spi_esp32_rx
// Self-checking bench for t07_spi_esp32_rx. Frames are described at word level
// (header, data words, trailing partial beats); a frame-level model turns them
// into per-cycle stimulus and per-cycle expected outputs, which one compare
// process checks every cycle. Observed writes are also logged and pinned
// against hand-computed literals for the directed frames.
// -----------------------------------------------------------------------------
module tb_t07_spi_esp32_rx;
   localparam int LANES    = 4;
   localparam int WORD_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int ADDR_MIN = 1;
   localparam int BEATS    = WORD_W / LANES;
`ifdef T07_SPI_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cs_n_in = 1'b1;
   logic [LANES-1:0]  esp_in = '0;
   logic              cs_n_out, sclk_out, wr_en, busy, frame_done, frame_err, par_err;
   logic [ADDR_W-1:0] wr_addr;
   logic [WORD_W-1:0] wr_data;

   t07_spi_esp32_rx #(
      .LANES(LANES), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .ADDR_MIN(ADDR_MIN)
   ) dut (
      .clk(clk), .rst(rst), .esp_in(esp_in), .cs_n_in(cs_n_in),
      .cs_n_out(cs_n_out), .sclk_out(sclk_out), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
      .frame_done(frame_done), .frame_err(frame_err), .par_err(par_err)
   );

   always #5 clk = ~clk;

   // Per-cycle stimulus and expectations (index = capturing clock edge).
   bit                stim_rst[$];
   bit                stim_cs[$];
   logic [LANES-1:0]  stim_esp[$];
   bit                exp_wr[$], exp_done[$], exp_ferr[$], exp_perr[$];
   bit                exp_busy[$], exp_zero[$];
   logic [ADDR_W-1:0] exp_addr[$];
   logic [WORD_W-1:0] exp_data[$];
   logic [WORD_W-1:0] fw[$];                 // data words of the next frame
   logic [ADDR_W+WORD_W-1:0] wr_log[$];      // every write the DUT made

   int errors = 0;
   int checks = 0;
   int cur    = -1;

   task automatic check(input string name, input int cyc,
                        input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [LANES-1:0] parity_of(input logic [WORD_W-1:0] w);
      logic [LANES-1:0] p;
      p = '0;
      for (int j = 0; j < WORD_W; j++) p[j % LANES] ^= w[j];
      return p;
   endfunction

   task automatic push_cycle(input bit r, input bit cs, input logic [LANES-1:0] d,
                             input bit bsy);
      stim_rst.push_back(r);
      stim_cs.push_back(cs);
      stim_esp.push_back(d);
      exp_wr.push_back(1'b0);
      exp_done.push_back(1'b0);
      exp_ferr.push_back(1'b0);
      exp_perr.push_back(1'b0);
      exp_busy.push_back(bsy);
      exp_zero.push_back(r);
      exp_addr.push_back('0);
      exp_data.push_back('0);
   endtask

   task automatic push_word(input logic [WORD_W-1:0] w, input bit bad, output int last);
      for (int b = 0; b < BEATS; b++)
         push_cycle(1'b0, 1'b0, LANES'(w >> (WORD_W - LANES*(b+1))), 1'b1);
      if (PAR != 0) push_cycle(1'b0, 1'b0, parity_of(w) ^ LANES'(bad), 1'b1);
      last = stim_cs.size() - 1;
   endtask

   // Header, the words in fw, then 'part' stray beats, then chip select high.
   task automatic add_frame(input logic [WORD_W-1:0] hdr, input int part,
                            input bit bad_hdr, input int bad_idx);
      int                last;
      bit                bad;
      logic [ADDR_W-1:0] a;
      push_word(hdr, bad_hdr && (PAR != 0), last);
      if (bad_hdr && (PAR != 0)) begin
         exp_perr[last] = 1'b1;
         exp_busy[last] = 1'b0;
         for (int k = 0; k < 3; k++) push_cycle(1'b0, 1'b0, LANES'($urandom), 1'b0);
         push_cycle(1'b0, 1'b1, LANES'($urandom), 1'b0);
         return;
      end
      a = hdr[ADDR_W-1:0];
      for (int j = 0; j < fw.size(); j++) begin
         bad = (j == bad_idx) && (PAR != 0);
         push_word(fw[j], bad, last);
         if (bad) exp_perr[last] = 1'b1;
         else begin
            exp_wr[last]   = 1'b1;
            exp_addr[last] = a;
            exp_data[last] = fw[j];
         end
         a = (a == ADDR_W'(2**ADDR_W - 1)) ? ADDR_W'(ADDR_MIN) : a + ADDR_W'(1);
      end
      for (int k = 0; k < part; k++) push_cycle(1'b0, 1'b0, LANES'($urandom), 1'b1);
      push_cycle(1'b0, 1'b1, LANES'($urandom), 1'b0);
      last = stim_cs.size() - 1;
      if (part > 0) exp_ferr[last] = 1'b1;
      else          exp_done[last] = 1'b1;
   endtask

   task automatic add_partial_header(input int k);
      for (int b = 0; b < k; b++) push_cycle(1'b0, 1'b0, LANES'($urandom), 1'b1);
      push_cycle(1'b0, 1'b1, LANES'($urandom), 1'b0);
      exp_ferr[stim_cs.size() - 1] = 1'b1;
   endtask

   // Header plus 5 data beats, reset, then chip select kept low: nothing may happen.
   task automatic add_reset_abort();
      int last;
      push_word(WORD_W'($urandom), 1'b0, last);
      for (int k = 0; k < 5; k++) push_cycle(1'b0, 1'b0, LANES'($urandom), 1'b1);
      for (int k = 0; k < 2; k++) push_cycle(1'b1, 1'b0, LANES'($urandom), 1'b0);
      for (int k = 0; k < 12; k++) push_cycle(1'b0, 1'b0, LANES'($urandom), 1'b0);
      push_cycle(1'b0, 1'b1, LANES'($urandom), 1'b0);
   endtask

   task automatic compare(input int i);
      check("wr_en", i, 64'(wr_en), 64'(exp_wr[i]));
      if (exp_wr[i]) begin
         check("wr_addr", i, 64'(wr_addr), 64'(exp_addr[i]));
         check("wr_data", i, 64'(wr_data), 64'(exp_data[i]));
      end
      check("frame_done", i, 64'(frame_done), 64'(exp_done[i]));
      check("frame_err",  i, 64'(frame_err),  64'(exp_ferr[i]));
      check("par_err",    i, 64'(par_err),    64'(exp_perr[i]));
      check("busy",       i, 64'(busy),       64'(exp_busy[i]));
      check("cs_n_out",   i, 64'(cs_n_out),   64'(stim_cs[i]));
      check("sclk_out",   i, 64'(sclk_out),   64'(1'b1));
      if (exp_zero[i]) begin
         check("rst_wr_addr", i, 64'(wr_addr), 64'(0));
         check("rst_wr_data", i, 64'(wr_data), 64'(0));
      end
      if (wr_en) wr_log.push_back({wr_addr, wr_data});
   endtask

   always @(posedge clk) begin
      #1;
      if (cur >= 0) compare(cur);
   end

   initial begin
      int n, part, bad_idx, gap;
      bit bad_hdr;

      // Reset, then chip select high so the receiver is armed.
      for (int k = 0; k < 3; k++) push_cycle(1'b1, 1'b1, '0, 1'b0);
      for (int k = 0; k < 2; k++) push_cycle(1'b0, 1'b1, '0, 1'b0);

      // Basic frame with address wrap 31 -> 1.
      fw.delete();
      fw.push_back(32'hDEADBEEF); fw.push_back(32'h12345678); fw.push_back(32'hCAFEF00D);
      add_frame(32'h0000001E, 0, 1'b0, -1);
      push_cycle(1'b0, 1'b1, '0, 1'b0);

      // Partial word after the header.
      fw.delete();
      add_frame(32'h00000005, 3, 1'b0, -1);
      // Chip select rises on the edge that would capture the last beat.
      add_frame(32'h00000003, BEATS + PAR - 1, 1'b0, -1);

      // Back-to-back frames separated by one chip-select-high cycle.
      fw.push_back(32'h11111111); fw.push_back(32'h22222222);
      add_frame(32'h0000001F, 0, 1'b0, -1);
      fw.delete();
      fw.push_back(32'h33333333);
      add_frame(32'hFFFFFF07, 0, 1'b0, -1);

      // Header-only frame, partial header, reset mid-frame.
      fw.delete();
      add_frame(32'h00000009, 0, 1'b0, -1);
      add_partial_header(3);
      add_reset_abort();

      // Parity: good word, bad word (dropped, address still advances), next word.
      fw.delete();
      fw.push_back(32'h00000001); fw.push_back(32'h00000001); fw.push_back(32'h0BADCAFE);
      add_frame(32'h00000010, 0, 1'b0, 1);
      fw.delete();
      fw.push_back(32'h00000042);
      add_frame(32'h00000004, 0, 1'b1, -1);

      // Randomised frames.
      for (int f = 0; f < 40; f++) begin
         fw.delete();
         n = int'($urandom_range(0, 5));
         for (int k = 0; k < n; k++) fw.push_back(WORD_W'($urandom));
         part    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, BEATS + PAR - 1)) : 0;
         bad_hdr = (PAR != 0) && ($urandom_range(0, 9) == 0);
         bad_idx = ((PAR != 0) && (n > 0) && ($urandom_range(0, 2) == 0))
                   ? int'($urandom_range(0, n - 1)) : -1;
         if ($urandom_range(0, 7) == 0)
            add_partial_header(int'($urandom_range(1, BEATS + PAR - 1)));
         else
            add_frame(WORD_W'($urandom), part, bad_hdr, bad_idx);
         gap = int'($urandom_range(0, 2));
         for (int k = 0; k < gap; k++) push_cycle(1'b0, 1'b1, LANES'($urandom), 1'b0);
      end

      // Drive one cycle per negative edge; the compare process checks after
      // the following rising edge.
      for (int c = 0; c < stim_cs.size(); c++) begin
         @(negedge clk);
         rst     = stim_rst[c];
         cs_n_in = stim_cs[c];
         esp_in  = stim_esp[c];
         cur     = c;
      end
      @(negedge clk);
      cur = -1;

      // Hand-computed writes of the directed frames.
      check("log_len", 0, 64'(wr_log.size() >= 9), 64'(1));
      check("lit0", 0, 64'(wr_log[0]), 64'({5'd30, 32'hDEADBEEF}));
      check("lit1", 1, 64'(wr_log[1]), 64'({5'd31, 32'h12345678}));
      check("lit2", 2, 64'(wr_log[2]), 64'({5'd1,  32'hCAFEF00D}));
      check("lit3", 3, 64'(wr_log[3]), 64'({5'd31, 32'h11111111}));
      check("lit4", 4, 64'(wr_log[4]), 64'({5'd1,  32'h22222222}));
      check("lit5", 5, 64'(wr_log[5]), 64'({5'd7,  32'h33333333}));
      check("lit6", 6, 64'(wr_log[6]), 64'({5'd16, 32'h00000001}));
      if (PAR != 0)
         check("lit7_par", 7, 64'(wr_log[7]), 64'({5'd18, 32'h0BADCAFE}));
      else
         check("lit7", 7, 64'(wr_log[7]), 64'({5'd17, 32'h00000001}));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
